led_pattern_seq: RTL and testbench

Parametrised LED pattern sequencer: a writable pattern RAM is stepped through at a programmable rate and the current word is driven to the LEDs. It supports loop, one-shot and ping-pong playback, plus start/stop control and a done pulse. It runs on the system clock using an internal tick enable, so no derived clock is needed. It sits in the SoC between the clock/reset block and the board LEDs, and the CPU bus writes it later.

---
 rtl/led_pattern_seq.sv | 148 ++++++++++++++
 tb/tb_led_pattern_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: steps through a writable pattern RAM at a programmable rate
// and drives the current word to the LEDs (loop / one-shot / ping-pong playback).
module led_pattern_seq #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    parameter int DIV   = 4194304,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = $clog2(DIV) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [1:0]       mode_i,
    input  logic [AW-1:0]    last_i,
    output logic [WIDTH-1:0] led_o,
    output logic [AW-1:0]    idx_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [1:0] M_ONESHOT  = 2'b01;
    localparam logic [1:0] M_PINGPONG = 2'b10;

    logic [WIDTH-1:0] mem_q [DEPTH];

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [AW-1:0]    last_q, last_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             dir_q, dir_d;   // 1 = counting down (ping-pong)
    logic             done_q, done_d;

    logic             tick;
    logic [AW-1:0]    nxt_idx;
    logic             nxt_dir;
    logic             fin;

    // Pattern RAM is not reset so software-loaded patterns survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            led_q   <= '0;
            pre_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            led_q   <= led_d;
            pre_q   <= pre_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign tick = (state_q == S_RUN) && (pre_q == PW'(DIV - 1));

    // Next step of the sequence, from the mode/last latched at start.
    always_comb begin
        nxt_idx = idx_q;
        nxt_dir = dir_q;
        fin     = 1'b0;
        case (mode_q)
            M_ONESHOT: begin
                if (idx_q == last_q) fin = 1'b1;
                else                 nxt_idx = idx_q + 1'b1;
            end
            M_PINGPONG: begin
                if (last_q == '0) begin
                    nxt_dir = ~dir_q;
                end else if (!dir_q) begin
                    if (idx_q == last_q) begin
                        nxt_dir = 1'b1;
                        nxt_idx = idx_q - 1'b1;
                    end else begin
                        nxt_idx = idx_q + 1'b1;
                    end
                end else begin
                    if (idx_q == '0) begin
                        nxt_dir = 1'b0;
                        nxt_idx = AW'(1);
                    end else begin
                        nxt_idx = idx_q - 1'b1;
                    end
                end
            end
            default: nxt_idx = (idx_q == last_q) ? '0 : idx_q + 1'b1;
        endcase
    end

    // Control priority: stop > start > tick.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        last_d  = last_q;
        idx_d   = idx_q;
        led_d   = led_q;
        pre_d   = pre_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (stop_i) begin
            if (state_q == S_RUN) state_d = S_IDLE;
        end else if (start_i) begin
            state_d = S_RUN;
            mode_d  = mode_i;
            last_d  = last_i;
            idx_d   = '0;
            dir_d   = 1'b0;
            pre_d   = '0;
            led_d   = mem_q[0];
        end else if (state_q == S_RUN) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                if (fin) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = nxt_idx;
                    dir_d = nxt_dir;
                    led_d = mem_q[nxt_idx];
                end
            end
        end
    end

    assign led_o  = led_q;
    assign idx_o  = idx_q;
    assign busy_o = (state_q == S_RUN);
    assign done_o = done_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq: stimulus queues per-cycle expectations,
// a monitor pops and compares them against two instances (DIV=4 and DIV=1).
module tb_led_pattern_seq;

    logic       clk = 1'b0;
    logic       resetn;
    logic       wr0, st0, sp0, wr1, st1, sp1;
    logic [2:0] wa0, la0, wa1, la1;
    logic [3:0] wd0, wd1;
    logic [1:0] md0, md1;
    logic [3:0] led0, led1;
    logic [2:0] idx0, idx1;
    logic       busy0, done0, busy1, done1;

    always #5 clk = ~clk;

    led_pattern_seq #(.WIDTH(4), .DEPTH(8), .DIV(4)) u_dut (
        .clk(clk), .resetn(resetn),
        .wr_en_i(wr0), .wr_addr_i(wa0), .wr_data_i(wd0),
        .start_i(st0), .stop_i(sp0), .mode_i(md0), .last_i(la0),
        .led_o(led0), .idx_o(idx0), .busy_o(busy0), .done_o(done0)
    );

    led_pattern_seq #(.WIDTH(4), .DEPTH(8), .DIV(1)) u_dut1 (
        .clk(clk), .resetn(resetn),
        .wr_en_i(wr1), .wr_addr_i(wa1), .wr_data_i(wd1),
        .start_i(st1), .stop_i(sp1), .mode_i(md1), .last_i(la1),
        .led_o(led1), .idx_o(idx1), .busy_o(busy1), .done_o(done1)
    );

    typedef struct {
        int         cyc;
        bit         sel;
        logic [3:0] led;
        logic [2:0] idx;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: at each falling edge, check every expectation due this cycle.
    initial begin
        exp_t e;
        logic [3:0] al;
        logic [2:0] ai;
        logic       ab, ad;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e  = q.pop_front();
                al = e.sel ? led1  : led0;
                ai = e.sel ? idx1  : idx0;
                ab = e.sel ? busy1 : busy0;
                ad = e.sel ? done1 : done0;
                n_vec++;
                if (e.cyc != cyc || al !== e.led || ai !== e.idx || ab !== e.busy || ad !== e.done) begin
                    n_err++;
                    $display("FAIL cyc%0d dut%0d: got led=%h idx=%0d busy=%b done=%b, expected led=%h idx=%0d busy=%b done=%b (due cyc%0d)",
                             cyc, e.sel, al, ai, ab, ad, e.led, e.idx, e.busy, e.done, e.cyc);
                end
            end
        end
    end

    bit         sel;
    logic [3:0] e_led;
    logic [2:0] e_idx;
    logic       e_busy;

    // Queue the state expected after the next rising edge, then advance one cycle.
    task automatic step(input logic [3:0] l, input logic [2:0] i, input logic b, input logic d);
        exp_t e;
        e.cyc = cyc + 1; e.sel = sel; e.led = l; e.idx = i; e.busy = b; e.done = d;
        q.push_back(e);
        e_led = l; e_idx = i; e_busy = b;
        @(negedge clk);
        wr0 = 1'b0; st0 = 1'b0; sp0 = 1'b0;
        wr1 = 1'b0; st1 = 1'b0; sp1 = 1'b0;
    endtask

    task automatic hold(input int n);
        for (int k = 0; k < n; k++) step(e_led, e_idx, e_busy, 1'b0);
    endtask

    // DUT0 steps every 4 clocks: three holding cycles, then the update.
    task automatic tick_to(input logic [3:0] l, input logic [2:0] i, input logic b, input logic d);
        hold(3);
        step(l, i, b, d);
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d);
        wr0 = 1'b1; wa0 = a; wd0 = d;
    endtask

    initial begin
        resetn = 1'b0;
        {wr0, st0, sp0, wr1, st1, sp1} = '0;
        {wa0, la0, wa1, la1} = '0;
        {wd0, wd1} = '0;
        {md0, md1} = '0;
        sel = 1'b0; e_led = '0; e_idx = '0; e_busy = 1'b0;
        @(negedge clk);

        // reset
        hold(3);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr(3'(i), 4'(1 << i));
            hold(1);
        end

        // loop, last=3
        md0 = 2'b00; la0 = 3'd3; st0 = 1'b1;
        step(4'h1, 3'd0, 1'b1, 1'b0);
        tick_to(4'h2, 3'd1, 1'b1, 1'b0);
        tick_to(4'h4, 3'd2, 1'b1, 1'b0);
        tick_to(4'h8, 3'd3, 1'b1, 1'b0);
        tick_to(4'h1, 3'd0, 1'b1, 1'b0);
        tick_to(4'h2, 3'd1, 1'b1, 1'b0);

        // one-shot, last=2: done pulses once, LEDs hold the final word
        md0 = 2'b01; la0 = 3'd2; st0 = 1'b1;
        step(4'h1, 3'd0, 1'b1, 1'b0);
        tick_to(4'h2, 3'd1, 1'b1, 1'b0);
        tick_to(4'h4, 3'd2, 1'b1, 1'b0);
        tick_to(4'h4, 3'd2, 1'b0, 1'b1);
        hold(4);

        // ping-pong, last=3
        md0 = 2'b10; la0 = 3'd3; st0 = 1'b1;
        step(4'h1, 3'd0, 1'b1, 1'b0);
        tick_to(4'h2, 3'd1, 1'b1, 1'b0);
        tick_to(4'h4, 3'd2, 1'b1, 1'b0);
        tick_to(4'h8, 3'd3, 1'b1, 1'b0);
        tick_to(4'h4, 3'd2, 1'b1, 1'b0);
        tick_to(4'h2, 3'd1, 1'b1, 1'b0);
        tick_to(4'h1, 3'd0, 1'b1, 1'b0);
        tick_to(4'h2, 3'd1, 1'b1, 1'b0);

        // stop at idx 2, hold 20 cycles, restart, then start+stop together
        md0 = 2'b00; la0 = 3'd3; st0 = 1'b1;
        step(4'h1, 3'd0, 1'b1, 1'b0);
        tick_to(4'h2, 3'd1, 1'b1, 1'b0);
        tick_to(4'h4, 3'd2, 1'b1, 1'b0);
        hold(1);
        sp0 = 1'b1;
        step(4'h4, 3'd2, 1'b0, 1'b0);
        hold(20);
        st0 = 1'b1;
        step(4'h1, 3'd0, 1'b1, 1'b0);
        hold(2);
        st0 = 1'b1; sp0 = 1'b1;
        step(4'h1, 3'd0, 1'b0, 1'b0);
        hold(5);

        // one-shot last=0; a start on the completion edge restarts without done
        md0 = 2'b01; la0 = 3'd0; st0 = 1'b1;
        step(4'h1, 3'd0, 1'b1, 1'b0);
        hold(3);
        st0 = 1'b1;
        step(4'h1, 3'd0, 1'b1, 1'b0);
        tick_to(4'h1, 3'd0, 1'b0, 1'b1);
        hold(2);

        // writes during RUN; mode/last changes ignored until next start
        md0 = 2'b00; la0 = 3'd3; st0 = 1'b1;
        step(4'h1, 3'd0, 1'b1, 1'b0);
        md0 = 2'b01; la0 = 3'd0;
        wr(3'd1, 4'hF);
        tick_to(4'hF, 3'd1, 1'b1, 1'b0);
        wr(3'd1, 4'h5);
        tick_to(4'h4, 3'd2, 1'b1, 1'b0);

        // reset mid-run
        resetn = 1'b0;
        step(4'h0, 3'd0, 1'b0, 1'b0);
        resetn = 1'b1;
        hold(2);

        // DIV=1, loop last=0: LEDs refresh from mem[0] every cycle
        sel = 1'b1; e_led = '0; e_idx = '0; e_busy = 1'b0;
        wr1 = 1'b1; wa1 = 3'd0; wd1 = 4'hA;
        step(4'h0, 3'd0, 1'b0, 1'b0);
        md1 = 2'b00; la1 = 3'd0; st1 = 1'b1;
        step(4'hA, 3'd0, 1'b1, 1'b0);
        hold(2);
        wr1 = 1'b1; wa1 = 3'd0; wd1 = 4'h3;
        step(4'hA, 3'd0, 1'b1, 1'b0);
        step(4'h3, 3'd0, 1'b1, 1'b0);
        hold(2);
        sp1 = 1'b1;
        step(4'h3, 3'd0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
